// File: rtl/fir_cmem_ctrl_if.sv
// Load, read and memory-side bus of the FIR coefficient memory controller.
interface fir_cmem_ctrl_if #(
  parameter int unsigned BITS       = 16,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  load_start;
  logic                  load_abort;
  logic                  load_valid;
  logic [BITS-1:0]       load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  coef_valid;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [BITS-1:0]       rd_data;
  logic                  mem_CEN;
  logic                  mem_WEN;
  logic [ADDR_WIDTH-1:0] mem_A;
  logic [BITS-1:0]       mem_D;
  logic [BITS-1:0]       mem_Q;

  // Controller view
  modport slave (
    input  load_start, load_abort, load_valid, load_data, rd_req, rd_addr, mem_Q,
    output load_ready, load_done, coef_valid, rd_gnt, rd_valid, rd_data,
           mem_CEN, mem_WEN, mem_A, mem_D
  );

  // Loader / FIR datapath / memory view
  modport master (
    output load_start, load_abort, load_valid, load_data, rd_req, rd_addr, mem_Q,
    input  load_ready, load_done, coef_valid, rd_gnt, rd_valid, rd_data,
           mem_CEN, mem_WEN, mem_A, mem_D
  );
endinterface

// File: rtl/fir_cmem_ctrl.sv
// FIR coefficient memory controller: sequential bulk reload plus 1-cycle reads.
module fir_cmem_ctrl #(
  parameter int unsigned BITS       = 16,
  parameter int unsigned WORD_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_cmem_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  coef_valid_q, coef_valid_d;
  logic                  load_done_q, load_done_d;
  logic                  rd_valid_q;

  logic                  load_ready;
  logic                  rd_gnt;
  logic                  mem_cen;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [BITS-1:0]       mem_d;

  // State and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      coef_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      coef_valid_q <= coef_valid_d;
      load_done_q  <= load_done_d;
      rd_valid_q   <= rd_gnt;
    end
  end

  // Next state, load handshake, read arbitration and memory port drive
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    coef_valid_d = coef_valid_q;
    load_done_d  = 1'b0;
    load_ready   = 1'b0;
    rd_gnt       = 1'b0;
    mem_cen      = 1'b1;
    mem_wen      = 1'b1;
    mem_a        = '0;
    mem_d        = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          // a reload invalidates the set immediately and wins over any read
          coef_valid_d = 1'b0;
          wr_ptr_d     = '0;
          state_d      = LOAD;
        end else if (bus.rd_req && coef_valid_q) begin
          rd_gnt  = 1'b1;
          mem_cen = 1'b0;
          mem_a   = bus.rd_addr;
        end
      end
      LOAD: begin
        if (bus.load_abort) begin
          // abandoned load: data this cycle is ignored, set stays invalid
          state_d = IDLE;
        end else begin
          load_ready = 1'b1;
          if (bus.load_valid) begin
            mem_cen = 1'b0;
            mem_wen = 1'b0;
            mem_a   = wr_ptr_q;
            mem_d   = bus.load_data;
            if (wr_ptr_q == LAST_ADDR) begin
              state_d      = IDLE;
              coef_valid_d = 1'b1;
              load_done_d  = 1'b1;
              wr_ptr_d     = '0;
            end else begin
              wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.load_ready = load_ready;
  assign bus.load_done  = load_done_q;
  assign bus.coef_valid = coef_valid_q;
  assign bus.rd_gnt     = rd_gnt;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_valid_q ? bus.mem_Q : '0;
  assign bus.mem_CEN    = mem_cen;
  assign bus.mem_WEN    = mem_wen;
  assign bus.mem_A      = mem_a;
  assign bus.mem_D      = mem_d;

endmodule

// File: tb/tb_fir_cmem_ctrl.sv
// Self-checking bench for fir_cmem_ctrl with a behavioural single-port memory.
module tb_fir_cmem_ctrl;

  localparam int unsigned BITS  = 16;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [BITS-1:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  wr_t             wq[$];
  logic [BITS-1:0] rq[$];
  logic [BITS-1:0] shadow [DEPTH];
  logic [BITS-1:0] mem    [DEPTH];
  logic [BITS-1:0] mem_q;

  fir_cmem_ctrl_if #(.BITS(BITS), .ADDR_WIDTH(AW)) bus ();

  fir_cmem_ctrl #(.BITS(BITS), .WORD_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, read data one cycle after the access
  always @(posedge clk) begin
    if (!bus.mem_CEN && !bus.mem_WEN) mem[bus.mem_A] <= bus.mem_D;
    if (!bus.mem_CEN && bus.mem_WEN) mem_q <= mem[bus.mem_A];
  end
  assign bus.mem_Q = mem_q;

  // Scoreboard: every memory write and every read return is matched in order
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.mem_CEN && !bus.mem_WEN) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: A=%0d D=%h, none expected", bus.mem_A, bus.mem_D);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if ({bus.mem_A, bus.mem_D} !== e) begin
            fails++;
            $display("FAIL write: A=%0d D=%h, expected A=%0d D=%h", bus.mem_A, bus.mem_D, e.a, e.d);
          end
        end
      end
      tests++;
      if (bus.rd_valid) begin
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rd_valid: rd_data=%h, none expected", bus.rd_data);
        end else begin
          logic [BITS-1:0] e;
          e = rq.pop_front();
          if (bus.rd_data !== e) begin
            fails++;
            $display("FAIL rd_data: got %h, expected %h", bus.rd_data, e);
          end
        end
      end else if (bus.rd_data !== '0) begin
        fails++;
        $display("FAIL rd_data_idle: got %h, expected 0", bus.rd_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.load_start = 1'b0;
    bus.load_abort = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.rd_req     = 1'b0;
    bus.rd_addr    = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #7;
    tests++;
    if ({bus.coef_valid, bus.load_done, bus.rd_valid, bus.load_ready, bus.rd_gnt} !== 5'b0) begin
      fails++;
      $display("FAIL reset_status: cv/ld/rv/lr/gnt=%b expected 00000",
               {bus.coef_valid, bus.load_done, bus.rd_valid, bus.load_ready, bus.rd_gnt});
    end
    tests++;
    if ({bus.mem_CEN, bus.mem_WEN, bus.mem_A, bus.mem_D} !== {2'b11, AW'(0), BITS'(0)}) begin
      fails++;
      $display("FAIL reset_mem: CEN=%b WEN=%b A=%0d D=%h expected 1 1 0 0",
               bus.mem_CEN, bus.mem_WEN, bus.mem_A, bus.mem_D);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_blocked(input string name);
    bus.rd_req  = 1'b1;
    bus.rd_addr = AW'(3);
    sample();
    tests++;
    if (bus.rd_gnt !== 1'b0 || bus.mem_CEN !== 1'b1) begin
      fails++;
      $display("FAIL %s: rd_gnt=%b mem_CEN=%b expected 0 1", name, bus.rd_gnt, bus.mem_CEN);
    end
    tick();
    bus.rd_req = 1'b0;
  endtask

  task automatic test_load(input bit gap, input logic [BITS-1:0] pat);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (gap && (i % 2 == 1)) begin
        bus.load_valid = 1'b0;
        bus.load_data  = 16'hDEAD;
        sample();
        tests++;
        if (bus.mem_CEN !== 1'b1 || bus.mem_WEN !== 1'b1) begin
          fails++;
          $display("FAIL gap_idle: CEN=%b WEN=%b expected 1 1", bus.mem_CEN, bus.mem_WEN);
        end
        tick();
      end
      bus.load_valid = 1'b1;
      bus.load_data  = BITS'(i) ^ pat;
      wq.push_back('{a: AW'(i), d: BITS'(i) ^ pat});
      shadow[i] = BITS'(i) ^ pat;
      sample();
      tests++;
      if (bus.load_ready !== 1'b1 || bus.coef_valid !== 1'b0) begin
        fails++;
        $display("FAIL load_word%0d: load_ready=%b coef_valid=%b expected 1 0", i, bus.load_ready, bus.coef_valid);
      end
      tick();
    end
    bus.load_valid = 1'b0;
    sample();
    tests++;
    if ({bus.load_done, bus.coef_valid, bus.load_ready} !== 3'b110) begin
      fails++;
      $display("FAIL load_end: done/cv/ready=%b expected 110", {bus.load_done, bus.coef_valid, bus.load_ready});
    end
    tick();
    sample();
    tests++;
    if (bus.load_done !== 1'b0) begin
      fails++;
      $display("FAIL load_done_pulse: load_done=%b expected 0", bus.load_done);
    end
    tick();
  endtask

  task automatic test_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [AW-1:0] addrs [3];
    addrs[0] = a0;
    addrs[1] = a1;
    addrs[2] = a2;
    for (int k = 0; k < 3; k++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = addrs[k];
      rq.push_back(shadow[addrs[k]]);
      sample();
      tests++;
      if ({bus.rd_gnt, bus.mem_CEN, bus.mem_WEN, bus.mem_A, bus.mem_D} !== {3'b101, addrs[k], BITS'(0)}) begin
        fails++;
        $display("FAIL read_issue: gnt=%b CEN=%b WEN=%b A=%0d D=%h expected 1 0 1 %0d 0",
                 bus.rd_gnt, bus.mem_CEN, bus.mem_WEN, bus.mem_A, bus.mem_D, addrs[k]);
      end
      tick();
    end
    bus.rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_abort();
    // same-cycle load_start beats a read
    bus.load_start = 1'b1;
    bus.rd_req     = 1'b1;
    bus.rd_addr    = AW'(7);
    sample();
    tests++;
    if (bus.rd_gnt !== 1'b0 || bus.mem_CEN !== 1'b1) begin
      fails++;
      $display("FAIL start_priority: rd_gnt=%b CEN=%b expected 0 1", bus.rd_gnt, bus.mem_CEN);
    end
    tick();
    bus.load_start = 1'b0;
    test_read_blocked("read_in_load");
    for (int i = 0; i < 10; i++) begin
      bus.load_start = (i == 5);
      bus.load_valid = 1'b1;
      bus.load_data  = BITS'(i) + 16'h4000;
      wq.push_back('{a: AW'(i), d: BITS'(i) + 16'h4000});
      shadow[i] = BITS'(i) + 16'h4000;
      tick();
    end
    bus.load_start = 1'b0;
    bus.load_abort = 1'b1;
    bus.load_data  = 16'hBEEF;
    sample();
    tests++;
    if (bus.load_ready !== 1'b0 || bus.mem_CEN !== 1'b1) begin
      fails++;
      $display("FAIL abort_cycle: load_ready=%b CEN=%b expected 0 1", bus.load_ready, bus.mem_CEN);
    end
    tick();
    bus.load_abort = 1'b0;
    bus.load_valid = 1'b0;
    sample();
    tests++;
    if (bus.load_ready !== 1'b0 || bus.coef_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_abort: load_ready=%b coef_valid=%b expected 0 0", bus.load_ready, bus.coef_valid);
    end
    tick();
    test_read_blocked("read_after_abort");
  endtask

  task automatic test_reset_mid_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = BITS'(i) + 16'h7000;
      wq.push_back('{a: AW'(i), d: BITS'(i) + 16'h7000});
      shadow[i] = BITS'(i) + 16'h7000;
      tick();
    end
    bus.load_data = 16'h7777;
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.mem_CEN, bus.mem_WEN, bus.load_ready, bus.coef_valid} !== 4'b1100) begin
      fails++;
      $display("FAIL async_reset: CEN/WEN/ready/cv=%b expected 1100",
               {bus.mem_CEN, bus.mem_WEN, bus.load_ready, bus.coef_valid});
    end
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    sample();
    tests++;
    if (bus.coef_valid !== 1'b0 || bus.load_ready !== 1'b0) begin
      fails++;
      $display("FAIL post_reset: coef_valid=%b load_ready=%b expected 0 0", bus.coef_valid, bus.load_ready);
    end
    tick();
    test_read_blocked("read_after_reset");
    test_load(1'b0, 16'h0000);
    test_reads(AW'(0), AW'(63), AW'(5));
  endtask

  task automatic test_drain();
    repeat (4) tick();
    tests++;
    if (wq.size() != 0 || rq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d writes and %0d reads outstanding, expected 0 0", wq.size(), rq.size());
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read_blocked("read_before_load");
    test_load(1'b0, 16'h0000);
    test_reads(AW'(0), AW'(63), AW'(5));
    test_load(1'b1, 16'hA5A5);
    test_reads(AW'(17), AW'(0), AW'(63));
    test_abort();
    test_reset_mid_load();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
